// File: rtl/i8088_bus_pkg.sv
// i8088_bus_pkg: shared types for the 8088-style bus initiator.
// Bus states, default widths and cycle-type codes.
package i8088_bus_pkg;

  localparam int BUS_ADDR_W = 20;
  localparam int BUS_DATA_W = 8;

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    T3   = 6'b001000,
    TW   = 6'b010000,
    T4   = 6'b100000
  } BusState_t;

  // Cycle type is {io, write}
  typedef logic [1:0] cyc_t;

  localparam cyc_t MEM_RD = 2'b00;
  localparam cyc_t MEM_WR = 2'b01;
  localparam cyc_t IO_RD  = 2'b10;
  localparam cyc_t IO_WR  = 2'b11;

  function automatic cyc_t cyc_type(input logic io, input logic wr);
    return {io, wr};
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// bus_wait_counter: counts wait states of one bus cycle.
// expired is high during the MAX_WAIT-th wait state.
module bus_wait_counter #(
  parameter int MAX_WAIT = 15
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX_WAIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/i8088_bus_initiator.sv
// i8088_bus_initiator: 8088-style T1-T2-T3-(TW)-T4 bus master.
// Define WAIT_TIMEOUT_EN to abort cycles after MAX_WAIT wait states.
module i8088_bus_initiator
  import i8088_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_W,
  parameter int DATA_WIDTH = BUS_DATA_W,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_io,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  ALE,
  output logic                  IOM,
  output logic                  RD_N,
  output logic                  WR_N,
  output logic [ADDR_WIDTH-1:0] ADDRESS,
  inout  wire  [DATA_WIDTH-1:0] DATA,
  input  logic                  READY
);

  BusState_t state, state_nx;

  cyc_t                  cyc_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic ready_c;
  logic drive;
  logic accept;
  logic is_wr;
  logic sample_ok;
  logic timeout;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end

  assign is_wr     = (cyc_q == MEM_WR) || (cyc_q == IO_WR);
  assign req_ready = ready_c && RESET_N;
  assign accept    = req_valid && req_ready;
  assign sample_ok = ((state == T3) || (state == TW)) && READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = T1;
      T1:      state_nx = T2;
      T2:      state_nx = T3;
      T3:      state_nx = READY ? T4 : TW;
      TW:      if (READY || timeout) state_nx = T4;
      T4:      state_nx = accept ? T1 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ALE       = 1'b0;
    RD_N      = 1'b1;
    WR_N      = 1'b1;
    drive     = 1'b0;
    ready_c   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: ready_c = 1'b1;
      T1:   ALE = 1'b1;
      T2, T3, TW: begin
        RD_N  = is_wr;
        WR_N  = !is_wr;
        drive = is_wr;
      end
      T4: begin
        ready_c   = 1'b1;
        rsp_valid = 1'b1;
        drive     = is_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cyc_q   <= MEM_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cyc_q   <= cyc_type(req_io, req_write);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (sample_ok) rdata_q <= is_wr ? '0 : DATA;
      else if (timeout) rdata_q <= '0;
    end
  end

  assign IOM       = (cyc_q == IO_RD) || (cyc_q == IO_WR);
  assign ADDRESS   = addr_q;
  assign rsp_rdata = rdata_q;
  assign DATA      = drive ? wdata_q : 'z;

`ifdef WAIT_TIMEOUT_EN
  logic wait_exp;
  logic err_q;

  bus_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .clear  (state == T2),
    .inc    (state == TW),
    .expired(wait_exp)
  );

  // A late READY on the last wait state still completes normally
  assign timeout = (state == TW) && wait_exp && !READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)       err_q <= 1'b0;
    else if (sample_ok) err_q <= 1'b0;
    else if (timeout)   err_q <= 1'b1;
  end

  assign rsp_error = err_q && (state == T4);
`else
  assign timeout   = 1'b0;
  assign rsp_error = 1'b0;
`endif

endmodule

// File: doc/i8088_bus_initiator.md
Name: i8088_bus_initiator

Overview:
- Bus master that runs 8088-style memory and I/O cycles on the shared bus interface that the memory/IO responder modules sit on.
- Accepts single read/write requests on a valid/ready host port.
- Sequences T1-T2-T3-(TW)*-T4, driving ALE, IOM, RD_N, WR_N and the address, and driving or sampling the 8-bit data bus.
- Returns one response per request.
- Used as the CPU stand-in in system benches and by DMA-style masters.

Parameters:
- ADDR_WIDTH, 20: width of the address bus and req_addr.
- DATA_WIDTH, 8: width of the data bus and the data ports.
- MAX_WAIT, 15: maximum TW cycles before abort. Used only with the optional feature.

Ports:
- CLK  input  1  bus clock; all state changes on its rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- req_valid  input  1  host request present.
- req_ready  output  1  request accepted on the edge where req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_io  input  1  1 = I/O cycle, 0 = memory cycle.
- req_addr  input  ADDR_WIDTH  target address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle pulse when a cycle completes.
- rsp_rdata  output  DATA_WIDTH  read data; valid with rsp_valid for reads, 0 for writes.
- rsp_error  output  1  cycle aborted on timeout; 0 unless WAIT_TIMEOUT_EN.
- ALE  output  1  address latch enable, active high.
- IOM  output  1  1 = I/O, 0 = memory; stable for the whole cycle.
- RD_N  output  1  read strobe, active low.
- WR_N  output  1  write strobe, active low.
- ADDRESS  output  ADDR_WIDTH  bus address; non-multiplexed, stable from T1 to end of T4.
- DATA  inout  DATA_WIDTH  bidirectional data bus.
- READY  input  1  target ready; low inserts wait states.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - ALE=0, RD_N=1, WR_N=1, IOM=0, ADDRESS=0, DATA=Z.
  - req_ready=0 while RESET_N is low; rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - Reset mid-cycle aborts the cycle with no response; the request is lost.
- States: IDLE, T1, T2, T3, TW, T4.
- req_ready=1 in IDLE and in T4, else 0.
- On accept:
  - Latch req_write, req_io, req_addr and req_wdata into registers.
  - ADDRESS and IOM update from the latched values on entry to T1.
- IDLE: go to T1 on accept, else stay.
- T1: ALE=1; strobes inactive; DATA=Z. Go to T2.
- T2:
  - ALE=0.
  - Read: RD_N=0, DATA=Z.
  - Write: WR_N=0, DATA driven with the latched wdata.
  - Go to T3.
- T3 and TW:
  - Strobes held, write data held.
  - READY is sampled at the rising edge ending the state.
  - READY=1: go to T4. For reads, capture DATA into rsp_rdata on that same edge.
  - READY=0: go to TW.
- T4:
  - RD_N=1, WR_N=1.
  - Write data still driven through T4; DATA=Z after T4.
  - rsp_valid=1 for exactly this cycle.
  - If accept occurs in T4, go to T1 (back-to-back); else go to IDLE.
- Latency:
  - Minimum: accept edge to rsp_valid = 4 cycles (T1..T4).
  - Each READY=0 sample adds one cycle.
- Bus contention rule: DATA is never driven while RD_N=0 or while in T1. Driven only in T2..T4 of writes.
- ALE is high for exactly one cycle per bus cycle.
- req_* inputs are ignored outside accept edges.

Optional Feature:
- Macro: WAIT_TIMEOUT_EN.
- Defined:
  - A counter clears on T3 entry and increments in each TW.
  - On MAX_WAIT consecutive TW cycles, go to T4 regardless of READY.
  - In that T4: rsp_error=1, rsp_rdata=0, strobes deasserted as normal.
- Undefined:
  - TW waits indefinitely.
  - rsp_error is tied to 0.
  - No counter logic is present.

Decomposition:
- Package i8088_bus_pkg:
  - BusState_t enum (one-hot: IDLE, T1, T2, T3, TW, T4).
  - Default ADDR_WIDTH and DATA_WIDTH constants.
  - Cycle-type encoding constants (MEM_RD, MEM_WR, IO_RD, IO_WR).
- Sub-module bus_wait_counter:
  - Clear, increment and expired flag, parameterised by MAX_WAIT.
  - Instantiated only under WAIT_TIMEOUT_EN.

Test Plan:
- Memory read, READY=1:
  - Stimulus: req addr 0x12345, io=0, write=0, responder returns 0xA5.
  - Required: ALE high in cycle 1 only; RD_N low in cycles 2-3; rsp_valid in cycle 4 with rsp_rdata=0xA5; IOM=0 throughout.
- I/O write, READY=1:
  - Stimulus: addr 0x003F8, wdata 0x5A.
  - Required: IOM=1; WR_N low in cycles 2-3; DATA=0x5A in cycles 2-4 and Z otherwise; responder memory at 0x003F8 = 0x5A.
- Wait states:
  - Stimulus: read with READY low for 3 samples.
  - Required: exactly 3 TW cycles; rsp_valid at cycle 7; data captured on the READY=1 edge.
- Back-to-back:
  - Stimulus: req_valid held high with write 0x00010←0x11, then read 0x00010.
  - Required: second ALE appears the cycle after the first T4; read returns 0x11; no DATA drive overlaps RD_N=0.
- Async reset during T2 of a write:
  - Required: WR_N=1, DATA=Z and ALE=0 immediately, before the next edge; no rsp_valid; IDLE after release.
- WAIT_TIMEOUT_EN with MAX_WAIT=4 and READY held low:
  - Required: T4 after 4 TW cycles; rsp_error=1, rsp_rdata=0.
  - Without the macro: the bench times out and rsp_error stays 0.
